bus_invert_pipe: RTL and testbench

Parametrised two-stage bus pipeline with optional bus-invert (BI) coding, for the low-power bus experiments. Stage 1 registers input word `A` onto the driven bus `B` plus an invert line `binv`. In BI mode it chooses whichever polarity toggles fewer bus wires. Stage 2 decodes `B`/`binv` back into `C`. The block also keeps a saturating count of bus-wire transitions, used for switching-activity and power comparison against the plain (non-encoded) pipeline.

---
 rtl/bus_invert_pipe.sv | 97 +++++++++
 tb/tb_bus_invert_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bus_invert_pipe.sv
// Two-stage bus pipeline with optional bus-invert coding and a saturating
// count of wire transitions on {binv, B} for switching-activity comparison.
module bus_invert_pipe #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          mode,
  input  logic          in_valid,
  input  logic [W-1:0]  A,
  input  logic          clr_count,
  output logic [W-1:0]  B,
  output logic          binv,
  output logic [W-1:0]  C,
  output logic          out_valid,
  output logic [CW-1:0] tcount
);

  localparam int DW = $clog2(W + 1);
  localparam int TW = $clog2(W + 2);
  localparam int SW = ((CW > TW) ? CW : TW) + 1;
  localparam logic [DW-1:0] HALF    = DW'(W / 2);
  localparam logic [SW-1:0] SAT_MAX = {{(SW - CW){1'b0}}, {CW{1'b1}}};

  function automatic logic [DW-1:0] f_pop_w(input logic [W-1:0] v);
    logic [DW-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) n = n + DW'(v[i]);
    return n;
  endfunction

  function automatic logic [TW-1:0] f_pop_w1(input logic [W:0] v);
    logic [TW-1:0] n;
    n = '0;
    for (int i = 0; i <= W; i++) n = n + TW'(v[i]);
    return n;
  endfunction

  logic [W-1:0]  r_b;
  logic          r_binv;
  logic          r_valid1;
  logic [W-1:0]  r_c;
  logic          r_out_valid;
  logic [CW-1:0] r_tcount;

  logic [DW-1:0] w_d;
  logic          w_inv;
  logic [W-1:0]  w_b_next;
  logic          w_binv_next;
  logic [TW-1:0] w_t;
  logic [SW-1:0] w_sum;
  logic [CW-1:0] w_tcount_next;

  // Encode: invert only on a strict majority of toggling wires; a tie keeps
  // true polarity. With no valid word the bus holds, so w_t comes out zero.
  always_comb begin
    w_d           = f_pop_w(A ^ r_b);
    w_inv         = mode && (w_d > HALF);
    w_b_next      = r_b;
    w_binv_next   = r_binv;
    if (in_valid) begin
      w_b_next    = w_inv ? ~A : A;
      w_binv_next = w_inv;
    end
    w_t           = f_pop_w1({w_binv_next, w_b_next} ^ {r_binv, r_b});
    w_sum         = SW'(r_tcount) + SW'(w_t);
    w_tcount_next = (w_sum > SAT_MAX) ? {CW{1'b1}} : w_sum[CW-1:0];
  end

  // NOTE: state is assigned with <= so every register samples pre-edge values;
  // the async reset clears all of it without waiting for a clock edge.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_b         <= '0;
      r_binv      <= 1'b0;
      r_valid1    <= 1'b0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
      r_tcount    <= '0;
    end else begin
      r_b         <= w_b_next;
      r_binv      <= w_binv_next;
      r_valid1    <= in_valid;
      if (r_valid1) r_c <= r_b ^ {W{r_binv}};
      r_out_valid <= r_valid1;
      r_tcount    <= clr_count ? '0 : w_tcount_next;
    end
  end

  assign B         = r_b;
  assign binv      = r_binv;
  assign C         = r_c;
  assign out_valid = r_out_valid;
  assign tcount    = r_tcount;

endmodule

// File: tb/tb_bus_invert_pipe.sv
// Self-checking bench for bus_invert_pipe: directed vector table, reset and
// counter-saturation sequences, then a randomized stream against a word-level model.
module tb_bus_invert_pipe;
  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  logic           ck = 1'b0;
  logic           rst;
  logic           mode;
  logic           in_valid;
  logic [W-1:0]   A;
  logic           clr_count;
  logic [W-1:0]   B, C, B4, C4;
  logic           binv, out_valid, binv4, out_valid4;
  logic [CW-1:0]  tcount;
  logic [CW4-1:0] tcount4;

  always #5 ck = ~ck;

  bus_invert_pipe #(.W(W), .CW(CW)) dut (
    .ck(ck), .rst(rst), .mode(mode), .in_valid(in_valid), .A(A),
    .clr_count(clr_count), .B(B), .binv(binv), .C(C),
    .out_valid(out_valid), .tcount(tcount)
  );

  bus_invert_pipe #(.W(W), .CW(CW4)) dut4 (
    .ck(ck), .rst(rst), .mode(mode), .in_valid(in_valid), .A(A),
    .clr_count(clr_count), .B(B4), .binv(binv4), .C(C4),
    .out_valid(out_valid4), .tcount(tcount4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input logic m, input logic v, input logic [W-1:0] a, input logic clr);
    mode = m; in_valid = v; A = a; clr_count = clr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_B"}, B, 0);
    check({tag, "_binv"}, binv, 0);
    check({tag, "_C"}, C, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_tcount"}, tcount, 0);
    check({tag, "_B4"}, B4, 0);
    check({tag, "_binv4"}, binv4, 0);
    check({tag, "_C4"}, C4, 0);
    check({tag, "_out_valid4"}, out_valid4, 0);
    check({tag, "_tcount4"}, tcount4, 0);
  endtask

  typedef struct {
    logic         m;
    logic         v;
    logic [W-1:0] a;
    logic         clr;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] c;
    logic         ov;
    int           cnt;
  } vec_t;

  vec_t tbl[13];

  // Word-level reference model state
  logic [W-1:0] m_b, m_c, nb, pb;
  logic         m_bi, m_v1, m_ov, nbi, inv, pbi;
  int           m_cnt, t, d, tog;
  logic [W-1:0] q[$];
  logic         rm, rv, rclr;
  logic [W-1:0] ra;

  initial begin
    //            m  v  A      clr B      bi C      ov cnt
    tbl[0]  = '{1, 1, 8'hFF, 0, 8'h00, 1, 8'h00, 0, 1};   // d=8: invert
    tbl[1]  = '{1, 1, 8'hF0, 0, 8'hF0, 0, 8'hFF, 1, 6};   // d=4 tie: true
    tbl[2]  = '{0, 1, 8'h11, 0, 8'h11, 0, 8'hF0, 1, 10};
    tbl[3]  = '{0, 0, 8'h55, 0, 8'h11, 0, 8'h11, 1, 10};  // gap: bus holds
    tbl[4]  = '{0, 1, 8'h22, 0, 8'h22, 0, 8'h11, 0, 14};
    tbl[5]  = '{0, 0, 8'h00, 0, 8'h22, 0, 8'h22, 1, 14};
    tbl[6]  = '{1, 1, 8'hDD, 0, 8'h22, 1, 8'h22, 0, 15};  // d=8 onto same bus
    tbl[7]  = '{0, 0, 8'h00, 1, 8'h22, 1, 8'hDD, 1, 0};   // clear while idle
    tbl[8]  = '{1, 1, 8'h0F, 1, 8'h0F, 0, 8'hDD, 0, 0};   // clear beats update
    tbl[9]  = '{0, 0, 8'h00, 0, 8'h0F, 0, 8'h0F, 1, 0};
    tbl[10] = '{1, 1, 8'hF2, 0, 8'h0D, 1, 8'h0F, 0, 2};   // d=7: invert
    tbl[11] = '{1, 1, 8'h12, 0, 8'hED, 1, 8'hF2, 1, 5};   // d=5: invert
    tbl[12] = '{0, 0, 8'h00, 0, 8'hED, 1, 8'h12, 1, 5};

    rst = 1'b0;
    drive(0, 0, 8'h00, 0);
    #2;
    check_all_zero("reset_init");
    #10;
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].m, tbl[i].v, tbl[i].a, tbl[i].clr);
      step();
      check($sformatf("vec%0d_B", i), B, tbl[i].b);
      check($sformatf("vec%0d_binv", i), binv, tbl[i].bi);
      check($sformatf("vec%0d_C", i), C, tbl[i].c);
      check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("vec%0d_tcount", i), tcount, 64'(tbl[i].cnt));
    end

    // Mid-stream async reset: clears between edges, pipeline is discarded.
    drive(0, 1, 8'h5A, 0); step();
    drive(1, 1, 8'hA5, 0); step();
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid");
    drive(0, 0, 8'h00, 0);
    #1;
    rst = 1'b1;
    step();
    check_all_zero("reset_flush");

    // Counter saturation on the CW=4 instance.
    begin
      logic [CW4-1:0] exp4 [5] = '{4'd8, 4'd15, 4'd15, 4'd15, 4'd15};
      for (int i = 0; i < 5; i++) begin
        drive(0, 1, (i % 2 == 0) ? 8'hFF : 8'h00, 0);
        step();
        check($sformatf("sat%0d_tcount4", i), tcount4, exp4[i]);
      end
    end
    drive(0, 1, 8'h00, 1); step();   // bus at 0xFF, so this update toggles 8
    check("sat_clr_tcount4", tcount4, 0);
    check("sat_clr_B4", B4, 8'h00);
    drive(0, 1, 8'hFF, 0); step();
    check("sat_after_clr_tcount4", tcount4, 8);
    drive(0, 0, 8'h00, 0); step();
    check("sat_idle_tcount4", tcount4, 8);

    // Randomized stream against the word-level model.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_b = '0; m_bi = 0; m_c = '0; m_v1 = 0; m_ov = 0; m_cnt = 0;
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      rm   = 1'($urandom_range(0, 1));
      rv   = ($urandom_range(0, 3) != 0);
      ra   = W'($urandom);
      rclr = ($urandom_range(0, 127) == 0);
      drive(rm, rv, ra, rclr);

      t = 0;
      nb = m_b; nbi = m_bi;
      if (rv) begin
        d   = $countones(ra ^ m_b);
        inv = rm && (d > W / 2);
        nb  = inv ? ~ra : ra;
        nbi = inv;
        t   = $countones({nbi, nb} ^ {m_bi, m_b});
      end
      m_cnt = rclr ? 0 : ((m_cnt + t > 65535) ? 65535 : m_cnt + t);
      m_b = nb; m_bi = nbi;
      if (m_v1) begin
        if (q.size() > 0) m_c = q.pop_front();
      end
      m_ov = m_v1;
      m_v1 = rv;
      if (rv) q.push_back(ra);

      pb = B; pbi = binv;
      step();
      check("rnd_B", B, m_b);
      check("rnd_binv", binv, m_bi);
      check("rnd_C", C, m_c);
      check("rnd_out_valid", out_valid, m_ov);
      check("rnd_tcount", tcount, 64'(m_cnt));
      if (rv && rm) begin
        tog = $countones({binv, B} ^ {pbi, pb});
        check("rnd_bi_toggle_le5", 64'(tog <= W / 2 + 1), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
